// File: rtl/store_outstanding_ctrl.sv
// Outstanding-store throttle between the write buffer and the D$ request port,
// with a fence handshake that drains all in-flight stores before releasing issue.
module store_outstanding_ctrl #(
  parameter int MaxOutstandingStores = 7,
  parameter int CntWidth = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_req_valid_i,
  output logic                st_req_ready_o,
  output logic                st_req_valid_o,
  input  logic                st_req_ready_i,
  input  logic                st_ack_i,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] outstanding_cnt_o,
  output logic                no_st_pending_o,
  output logic                err_underflow_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstandingStores);
  localparam logic [CntWidth-1:0] One    = CntWidth'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cnt_next;
  logic                err;
  logic                full;
  logic                allow;
  logic                issue;
  logic                ack_ok;
  logic                ack_under;

  // Throttle decisions use the registered count, so an ack cannot free a slot
  // for an issue in the same cycle.
  assign full      = (cnt == MaxCnt);
  assign allow     = (state == IDLE) && !full;
  assign issue     = st_req_valid_i && st_req_ready_i && allow;
  assign ack_ok    = st_ack_i && (cnt != '0);
  assign ack_under = st_ack_i && (cnt == '0);

  always_comb begin
    cnt_next = cnt;
    case ({issue, ack_ok})
      2'b10:   cnt_next = cnt + One;
      2'b01:   cnt_next = cnt - One;
      default: cnt_next = cnt;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fence_i) state_next = DRAIN;
      DRAIN:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (ack_under) err <= 1'b1;
    end
  end

  assign st_req_valid_o    = st_req_valid_i && allow;
  assign st_req_ready_o    = st_req_ready_i && allow;
  assign fence_done_o      = (state == DONE);
  assign outstanding_cnt_o = cnt;
  assign no_st_pending_o   = (cnt == '0);
  assign err_underflow_o   = err;

endmodule
